// File: rtl/uart_pattern_scan.sv
// ---------------------------------------------------------------------------
// uart_pattern_scan
//   UART receiver (8N1-style, optional parity) that streams every accepted
//   data bit into a 16-bit history window and flags when the newest
//   PAT_WIDTH bits equal PATTERN.
//
// Ports
//   clk           : system clock, all logic on the rising edge
//   rst_n         : synchronous active-low reset
//   rx            : asynchronous serial line, idle high
//   bit_strobe    : one-cycle pulse per accepted data bit
//   shift_window  : data-bit history, newest bit in bit 0
//   match         : one-cycle pulse, one cycle after the strobe that completes the pattern
//   match_count   : saturating count of match pulses
//   rx_data       : last received byte, LSB-aligned
//   frame_done    : one-cycle pulse at the end of each completed frame
//   framing_error : stop-bit status of the last completed frame
//   parity_error  : parity status of the last completed frame
//   busy          : receiver FSM is outside IDLE
//   dbg_state     : current FSM state encoding
//
// Handshake: there is no back-pressure; every strobe/pulse output is a
// single-cycle event that the consumer must capture when it is high.
// ---------------------------------------------------------------------------
module uart_pattern_scan #(
   parameter int          CLK_FREQ_HZ = 50_000_000,
   parameter int          BAUD_RATE   = 115_200,
   parameter int          DATA_BITS   = 8,
   parameter int          PARITY_MODE = 0,
   parameter int          PAT_WIDTH   = 4,
   parameter logic [15:0] PATTERN     = 16'h0007,
   parameter int          OVERLAP     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx,
   output logic        bit_strobe,
   output logic [15:0] shift_window,
   output logic        match,
   output logic [15:0] match_count,
   output logic [7:0]  rx_data,
   output logic        frame_done,
   output logic        framing_error,
   output logic        parity_error,
   output logic        busy,
   output logic [2:0]  dbg_state
);

   localparam int BIT_PERIOD  = CLK_FREQ_HZ / BAUD_RATE;
   localparam int HALF_PERIOD = BIT_PERIOD / 2;
   localparam int CW          = $clog2(BIT_PERIOD + 1);

   localparam logic [CW-1:0] LD_HALF  = CW'(HALF_PERIOD - 1);
   localparam logic [CW-1:0] LD_FULL  = CW'(BIT_PERIOD - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
   localparam logic [4:0]    FILL_MAX = 5'(PAT_WIDTH);
   localparam logic [15:0]   PAT_MASK = 16'((32'd1 << PAT_WIDTH) - 32'd1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   state_t        r_state;
   logic          r_rx_meta;
   logic          r_rx_sync;
   logic [CW-1:0] r_baud_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_data_buf;
   logic          r_par_acc;
   logic          r_par_err_pend;
   logic          r_bit_strobe;
   logic [15:0]   r_shift_window;
   logic          r_frame_done;
   logic [7:0]    r_rx_data;
   logic          r_framing_error;
   logic          r_parity_error;
   logic [4:0]    r_fill;
   logic          r_match;
   logic [15:0]   r_match_count;

   logic w_rx;
   logic w_tick;
   logic w_sample_data;
   logic w_window_hit;

   // Two-flop synchronizer; flops reset to the idle line level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
      end
   end

   assign w_rx          = r_rx_sync;
   assign w_tick        = (r_baud_cnt == '0);
   assign w_sample_data = (r_state == S_DATA) && w_tick;

   // Receiver FSM with its registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_baud_cnt      <= '0;
         r_bit_idx       <= '0;
         r_data_buf      <= '0;
         r_par_acc       <= 1'b0;
         r_par_err_pend  <= 1'b0;
         r_bit_strobe    <= 1'b0;
         r_shift_window  <= '0;
         r_frame_done    <= 1'b0;
         r_rx_data       <= '0;
         r_framing_error <= 1'b0;
         r_parity_error  <= 1'b0;
      end else begin
         r_bit_strobe <= 1'b0;
         r_frame_done <= 1'b0;
         // Free-running down count; each state reloads it when it samples.
         if (r_baud_cnt != '0) r_baud_cnt <= r_baud_cnt - 1'b1;
         case (r_state)
            S_IDLE: begin
               if (!w_rx) begin
                  r_state    <= S_START;
                  r_baud_cnt <= LD_HALF;
               end
            end
            S_START: begin
               if (w_tick) begin
                  if (!w_rx) begin
                     r_state    <= S_DATA;
                     r_baud_cnt <= LD_FULL;
                     r_bit_idx  <= '0;
                     r_par_acc  <= 1'b0;
                     r_data_buf <= '0;
                  end else begin
                     // Start bit did not survive to mid-bit: a glitch.
                     r_state <= S_IDLE;
                  end
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  r_baud_cnt            <= LD_FULL;
                  r_bit_strobe          <= 1'b1;
                  r_shift_window        <= {r_shift_window[14:0], w_rx};
                  r_data_buf[r_bit_idx] <= w_rx;
                  r_par_acc             <= r_par_acc ^ w_rx;
                  if (r_bit_idx == LAST_BIT) begin
                     r_state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (w_tick) begin
                  r_baud_cnt     <= LD_FULL;
                  // Even: data^parity must be 0; odd: must be 1.
                  r_par_err_pend <= (r_par_acc ^ w_rx) != (PARITY_MODE == 2);
                  r_state        <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_tick) begin
                  r_frame_done    <= 1'b1;
                  r_framing_error <= !w_rx;
                  r_parity_error  <= (PARITY_MODE != 0) && r_par_err_pend;
                  r_rx_data       <= r_data_buf;
                  r_state         <= w_rx ? S_IDLE : S_WAIT_IDLE;
               end
            end
            S_WAIT_IDLE: begin
               // A low stop bit leaves the line low; wait for it to idle.
               if (w_rx) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The window already holds the new bit in the strobe cycle, so the
   // comparison there yields a match pulse on the following cycle.
   assign w_window_hit = (r_fill >= FILL_MAX) &&
                         ((r_shift_window & PAT_MASK) == (PATTERN & PAT_MASK));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fill        <= '0;
         r_match       <= 1'b0;
         r_match_count <= '0;
      end else begin
         r_match <= 1'b0;
         if (r_bit_strobe && w_window_hit) begin
            r_match <= 1'b1;
            if (r_match_count != 16'hFFFF) r_match_count <= r_match_count + 1'b1;
            if (OVERLAP == 0) r_fill <= '0;
         end
         // Bit samples are at least BIT_PERIOD apart, never on a match edge.
         if (w_sample_data && (r_fill != FILL_MAX)) r_fill <= r_fill + 1'b1;
      end
   end

   assign bit_strobe    = r_bit_strobe;
   assign shift_window  = r_shift_window;
   assign match         = r_match;
   assign match_count   = r_match_count;
   assign rx_data       = r_rx_data;
   assign frame_done    = r_frame_done;
   assign framing_error = r_framing_error;
   assign parity_error  = r_parity_error;
   assign busy          = (r_state != S_IDLE);
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_uart_pattern_scan.sv
// ---------------------------------------------------------------------------
// tb_uart_pattern_scan
//   Four receivers: u_a (pattern 7, overlap), u_b (pattern F, overlap),
//   u_c (pattern F, no overlap) share serial lane 0; u_d (even parity)
//   listens on lane 1. The model keeps the bit history each lane carries
//   since reset and derives window, match and frame results from it.
// ---------------------------------------------------------------------------
module tb_uart_pattern_scan;

   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD   = 100_000;
   localparam int BP     = CLK_HZ / BAUD;
   localparam int PW     = 4;

   typedef struct packed {
      logic [7:0] data;
      logic       fe;
      logic       pe;
   } frame_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   logic rst_at_edge = 1'b1;
   logic rx0, rx1;

   always #5 clk = ~clk;
   always @(posedge clk) rst_at_edge <= rst_n;

   // ---------------- DUTs ----------------
   logic [3:0]       bs, m, fd, fe, pe, busy;
   logic [3:0][15:0] sw, mc;
   logic [3:0][7:0]  rxd;
   logic [3:0][2:0]  dbg;

   uart_pattern_scan #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PATTERN(16'h0007), .OVERLAP(1)) u_a (
      .clk(clk), .rst_n(rst_n), .rx(rx0), .bit_strobe(bs[0]), .shift_window(sw[0]), .match(m[0]),
      .match_count(mc[0]), .rx_data(rxd[0]), .frame_done(fd[0]), .framing_error(fe[0]),
      .parity_error(pe[0]), .busy(busy[0]), .dbg_state(dbg[0]));
   uart_pattern_scan #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PATTERN(16'h000F), .OVERLAP(1)) u_b (
      .clk(clk), .rst_n(rst_n), .rx(rx0), .bit_strobe(bs[1]), .shift_window(sw[1]), .match(m[1]),
      .match_count(mc[1]), .rx_data(rxd[1]), .frame_done(fd[1]), .framing_error(fe[1]),
      .parity_error(pe[1]), .busy(busy[1]), .dbg_state(dbg[1]));
   uart_pattern_scan #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PATTERN(16'h000F), .OVERLAP(0)) u_c (
      .clk(clk), .rst_n(rst_n), .rx(rx0), .bit_strobe(bs[2]), .shift_window(sw[2]), .match(m[2]),
      .match_count(mc[2]), .rx_data(rxd[2]), .frame_done(fd[2]), .framing_error(fe[2]),
      .parity_error(pe[2]), .busy(busy[2]), .dbg_state(dbg[2]));
   uart_pattern_scan #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY_MODE(1), .PATTERN(16'h0007), .OVERLAP(1)) u_d (
      .clk(clk), .rst_n(rst_n), .rx(rx1), .bit_strobe(bs[3]), .shift_window(sw[3]), .match(m[3]),
      .match_count(mc[3]), .rx_data(rxd[3]), .frame_done(fd[3]), .framing_error(fe[3]),
      .parity_error(pe[3]), .busy(busy[3]), .dbg_state(dbg[3]));

   function automatic int lane_of(input int k);
      return (k == 3) ? 1 : 0;
   endfunction
   function automatic logic [15:0] pat_of(input int k);
      return (k == 1 || k == 2) ? 16'h000F : 16'h0007;
   endfunction
   function automatic bit ovl_of(input int k);
      return (k != 2);
   endfunction

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-lane expectations written by the drivers.
   logic   lane_bits   [2][128];
   int     lane_wr     [2];
   frame_t lane_frames [2][16];
   int     lane_fwr    [2];

   // Per-receiver model state.
   int          rd [4], n_since [4], st_cnt [4], fd_cnt [4], frd [4];
   logic [15:0] m_win [4], mcnt [4];
   logic        pend [4];
   logic [63:0] obs_mask [4];
   logic [7:0]  last_rxd [4];
   logic        last_fe [4], last_pe [4];

   always @(negedge clk) begin
      if (!rst_at_edge) begin
         for (int l = 0; l < 2; l++) begin
            lane_wr[l]  = 0;
            lane_fwr[l] = 0;
         end
         for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_outputs_%0d", k),
                  {bs[k], sw[k], m[k], mc[k], rxd[k], fd[k], fe[k], pe[k], busy[k], dbg[k]}, '0);
            rd[k] = 0; n_since[k] = 0; st_cnt[k] = 0; fd_cnt[k] = 0; frd[k] = 0;
            m_win[k] = '0; mcnt[k] = '0; pend[k] = 1'b0; obs_mask[k] = '0;
            last_rxd[k] = '0; last_fe[k] = 1'b0; last_pe[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            automatic int   ln    = lane_of(k);
            automatic logic exp_m = pend[k];
            pend[k] = 1'b0;
            check($sformatf("match_%0d", k), m[k], exp_m);
            if (exp_m && mcnt[k] != 16'hFFFF) mcnt[k]++;
            if (m[k] && st_cnt[k] >= 1 && st_cnt[k] <= 64) obs_mask[k][st_cnt[k]-1] = 1'b1;
            if (bs[k]) begin
               check($sformatf("strobe_expected_%0d", k), rd[k] < lane_wr[ln], 1);
               if (rd[k] < lane_wr[ln]) begin
                  automatic int  have;
                  automatic bit  hit = 1;
                  m_win[k] = {m_win[k][14:0], lane_bits[ln][rd[k]]};
                  rd[k]++;
                  n_since[k]++;
                  st_cnt[k]++;
                  have = ovl_of(k) ? rd[k] : n_since[k];
                  if (have < PW) hit = 0;
                  else
                     for (int j = 0; j < PW; j++)
                        if (lane_bits[ln][rd[k]-1-j] != pat_of(k)[j]) hit = 0;
                  pend[k] = hit;
                  if (hit && !ovl_of(k)) n_since[k] = 0;
               end
            end
            check($sformatf("window_%0d", k), sw[k], m_win[k]);
            check($sformatf("match_count_%0d", k), mc[k], mcnt[k]);
            if (fd[k]) begin
               fd_cnt[k]++;
               check($sformatf("frame_expected_%0d", k), frd[k] < lane_fwr[ln], 1);
               if (frd[k] < lane_fwr[ln]) begin
                  last_rxd[k] = lane_frames[ln][frd[k]].data;
                  last_fe[k]  = lane_frames[ln][frd[k]].fe;
                  last_pe[k]  = lane_frames[ln][frd[k]].pe;
                  frd[k]++;
               end
            end
            check($sformatf("frame_status_%0d", k), {rxd[k], fe[k], pe[k]},
                  {last_rxd[k], last_fe[k], last_pe[k]});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_rx(input int lane, input logic v);
      if (lane == 0) rx0 = v;
      else           rx1 = v;
   endtask

   // abort_at >= 0 pulses reset partway into that data bit and abandons the frame.
   task automatic send_frame(input int lane, input logic [7:0] data, input logic pbit,
                             input logic stop, input int abort_at);
      frame_t f;
      f.data = data;
      f.fe   = !stop;
      f.pe   = (lane == 1) ? ((^data) ^ pbit) : 1'b0;
      lane_frames[lane][lane_fwr[lane]] = f;
      lane_fwr[lane]++;
      set_rx(lane, 1'b0);
      hold(BP);
      for (int i = 0; i < 8; i++) begin
         lane_bits[lane][lane_wr[lane]] = data[i];
         lane_wr[lane]++;
         set_rx(lane, data[i]);
         if (i == abort_at) begin
            hold(3);
            rst_n = 1'b0;
            set_rx(lane, 1'b1);
            hold(4);
            rst_n = 1'b1;
            hold(3);
            return;
         end
         hold(BP);
      end
      if (lane == 1) begin
         set_rx(lane, pbit);
         hold(BP);
      end
      set_rx(lane, stop);
      hold(BP);
   endtask

   // ---------------- stimulus ----------------
   int fd_before, st_before;
   logic saw_busy;

   initial begin
      rst_n = 1'b0;
      rx0   = 1'b1;
      rx1   = 1'b1;
      hold(4);
      rst_n = 1'b1;
      hold(3);
      check("idle_window", sw[0], 16'h0000);
      check("idle_busy", busy[0], 1'b0);

      // CE, EE, F0 sent LSB first; pattern 0111 ends at bits 3, 11, 15, 22.
      send_frame(0, 8'hCE, 1'b0, 1'b1, -1); hold(2);
      send_frame(0, 8'hEE, 1'b0, 1'b1, -1); hold(2);
      send_frame(0, 8'hF0, 1'b0, 1'b1, -1); hold(4);
      check("p7_match_indices", obs_mask[0], 64'h0000_0000_0040_8808);
      check("p7_match_count", mc[0], 16'd4);
      check("p7_framing_error", fe[0], 1'b0);
      check("p7_frame_done_count", fd_cnt[0], 3);
      check("p7_rx_data", rxd[0], 8'hF0);

      // FF: overlapping matches at 3..7, non-overlapping at 3 and 7.
      rst_n = 1'b0; hold(3); rst_n = 1'b1; hold(3);
      send_frame(0, 8'hFF, 1'b0, 1'b1, -1); hold(4);
      check("ff_ovl_indices", obs_mask[1], 64'h0000_0000_0000_00F8);
      check("ff_ovl_count", mc[1], 16'd5);
      check("ff_novl_indices", obs_mask[2], 64'h0000_0000_0000_0088);
      check("ff_novl_count", mc[2], 16'd2);

      // Even parity on A5 (four ones): parity bit 0 is good, 1 is bad.
      send_frame(1, 8'hA5, 1'b0, 1'b1, -1); hold(4);
      check("par_ok_error", pe[3], 1'b0);
      check("par_ok_window", sw[3][7:0], 8'hA5);
      check("par_ok_rx_data", rxd[3], 8'hA5);
      send_frame(1, 8'hA5, 1'b1, 1'b1, -1); hold(4);
      check("par_bad_error", pe[3], 1'b1);
      check("par_bad_window", sw[3], 16'hA5A5);
      check("par_bad_strobes", st_cnt[3], 16);

      // Low stop bit: busy stays up while the line stays low.
      fd_before = fd_cnt[0];
      send_frame(0, 8'hA5, 1'b0, 1'b0, -1);
      for (int i = 0; i < 30; i++) begin
         check("wait_idle_busy", busy[0], 1'b1);
         hold(1);
      end
      check("stop_low_framing_error", fe[0], 1'b1);
      check("stop_low_frames", fd_cnt[0] - fd_before, 1);
      rx0 = 1'b1;
      for (int i = 0; i < 8 && busy[0]; i++) hold(1);
      check("wait_idle_release", busy[0], 1'b0);
      hold(4);

      // Short low pulse on the line: rejected as a glitch.
      st_before = st_cnt[0];
      fd_before = fd_cnt[0];
      saw_busy  = 1'b0;
      rx0 = 1'b0;
      hold(BP / 4);
      rx0 = 1'b1;
      for (int i = 0; i < BP; i++) begin
         hold(1);
         if (busy[0]) saw_busy = 1'b1;
      end
      check("glitch_seen_busy", saw_busy, 1'b1);
      check("glitch_busy_low", busy[0], 1'b0);
      check("glitch_no_strobe", st_cnt[0] - st_before, 0);
      check("glitch_no_frame", fd_cnt[0] - fd_before, 0);

      // Reset during data bit 3, then a clean frame of 55.
      send_frame(0, 8'h55, 1'b0, 1'b1, 3);
      hold(2);
      send_frame(0, 8'h55, 1'b0, 1'b1, -1); hold(4);
      check("post_reset_rx_data", rxd[0], 8'h55);
      check("post_reset_strobes", st_cnt[0], 8);
      check("post_reset_window", sw[0], 16'h00AA);
      check("post_reset_frames", fd_cnt[0], 1);

      for (int k = 0; k < 4; k++) begin
         check($sformatf("bits_consumed_%0d", k), rd[k], lane_wr[lane_of(k)]);
         check($sformatf("frames_consumed_%0d", k), frd[k], lane_fwr[lane_of(k)]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
